// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate/commit ring with per-port write-back,
// operand bypass, count-based almost-full and a registered one-cycle mispredict flush.
module rob_param #(
  parameter int DEPTH        = 16,
  parameter int TAG_W        = 4,
  parameter int NUM_WB       = 3,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int REG_W        = 5,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     alloc_valid,
  input  logic                     alloc_done,
  input  logic [REG_W-1:0]         alloc_dest,
  input  logic [2:0]               alloc_type,
  output logic [TAG_W-1:0]         alloc_tag,
  output logic                     full_o,
  output logic [TAG_W:0]           count_o,
  input  logic                     q1_valid,
  input  logic [TAG_W-1:0]         q1_tag,
  output logic                     q1_hit,
  output logic [DATA_W-1:0]        q1_data,
  input  logic                     q2_valid,
  input  logic [TAG_W-1:0]         q2_tag,
  output logic                     q2_hit,
  output logic [DATA_W-1:0]        q2_data,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_WB-1:0]        wb_jump,
  input  logic [NUM_WB*ADDR_W-1:0] wb_pc,
  output logic                     commit_valid,
  output logic [REG_W-1:0]         commit_dest,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [DATA_W-1:0]        commit_data,
  output logic                     lsb_commit,
  output logic                     redirect_valid,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic                     flush
);

  typedef enum logic [2:0] {
    T_REG        = 3'd0,
    T_STORE      = 3'd1,
    T_LOAD       = 3'd2,
    T_PC         = 3'd3,
    T_PC_AND_REG = 3'd4
  } rob_type_e;

  localparam logic [TAG_W:0] DEPTH_C  = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] MARGIN_C = (TAG_W+1)'(AFULL_MARGIN);

  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q, count_next;
  logic [DEPTH-1:0]  valid_q, done_q, jump_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [REG_W-1:0]  dest_q [DEPTH];
  rob_type_e         type_q [DEPTH];

  logic [DEPTH-1:0]  wb_hit, wb_jmp;
  logic [DATA_W-1:0] wb_dat [DEPTH];
  logic [ADDR_W-1:0] wb_adr [DEPTH];

  logic      alloc_fire, commit_fire, mispredict;
  rob_type_e head_type;

  assign alloc_tag   = tail_q;
  assign count_o     = count_q;
  assign head_type   = type_q[head_q];
  assign alloc_fire  = rdy && !flush && alloc_valid && (count_q < DEPTH_C);
  assign commit_fire = rdy && !flush && (count_q != '0) && done_q[head_q];
  assign mispredict  = commit_fire && jump_q[head_q] &&
                       (head_type inside {T_PC, T_PC_AND_REG});

  // Per-entry write-back select: lowest port wins, only live entries outside flush/stall.
  always_comb begin : wb_select
    logic hit;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      hit       = 1'b0;
      wb_jmp[e] = 1'b0;
      wb_dat[e] = '0;
      wb_adr[e] = '0;
      for (int unsigned i = 0; i < NUM_WB; i++) begin
        if (!hit && wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == TAG_W'(e))) begin
          hit       = 1'b1;
          wb_jmp[e] = wb_jump[i];
          wb_dat[e] = wb_data[i*DATA_W +: DATA_W];
          wb_adr[e] = wb_pc[i*ADDR_W +: ADDR_W];
        end
      end
      wb_hit[e] = hit && valid_q[e] && rdy && !flush;
    end
  end

  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    if (q1_valid && valid_q[q1_tag]) begin
      if (done_q[q1_tag]) begin
        q1_hit  = 1'b1;
        q1_data = data_q[q1_tag];
      end else if (wb_hit[q1_tag]) begin
        q1_hit  = 1'b1;
        q1_data = wb_dat[q1_tag];
      end
    end
    if (q2_valid && valid_q[q2_tag]) begin
      if (done_q[q2_tag]) begin
        q2_hit  = 1'b1;
        q2_data = data_q[q2_tag];
      end else if (wb_hit[q2_tag]) begin
        q2_hit  = 1'b1;
        q2_data = wb_dat[q2_tag];
      end
    end
  end

  always_comb begin
    count_next = count_q;
    if (alloc_fire && !commit_fire)
      count_next = count_q + 1'b1;
    else if (!alloc_fire && commit_fire)
      count_next = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      full_o         <= 1'b0;
      valid_q        <= '0;
      done_q         <= '0;
      jump_q         <= '0;
      commit_valid   <= 1'b0;
      commit_dest    <= '0;
      commit_tag     <= '0;
      commit_data    <= '0;
      lsb_commit     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else if (!rdy) begin
      commit_valid   <= 1'b0;
      lsb_commit     <= 1'b0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
    end else begin
      commit_valid   <= 1'b0;
      lsb_commit     <= 1'b0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (wb_hit[e]) begin
          done_q[e] <= 1'b1;
          jump_q[e] <= wb_jmp[e];
        end
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= alloc_done;
        jump_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
        commit_valid    <= head_type inside {T_REG, T_LOAD, T_PC_AND_REG};
        lsb_commit      <= head_type inside {T_STORE, T_LOAD};
        commit_dest     <= dest_q[head_q];
        commit_tag      <= head_q;
        commit_data     <= data_q[head_q];
      end
      count_q <= count_next;
      full_o  <= (DEPTH_C - count_next) <= MARGIN_C;
      // Mispredict squashes everything, including this edge's allocation and write-backs.
      if (mispredict) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= pc_q[head_q];
        flush          <= 1'b1;
        head_q         <= '0;
        tail_q         <= '0;
        count_q        <= '0;
        full_o         <= 1'b0;
        valid_q        <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (wb_hit[e]) begin
        data_q[e] <= wb_dat[e];
        pc_q[e]   <= wb_adr[e];
      end
    end
    if (alloc_fire) begin
      data_q[tail_q] <= '0;
      pc_q[tail_q]   <= '0;
      dest_q[tail_q] <= alloc_dest;
      type_q[tail_q] <= rob_type_e'(alloc_type);
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed vector table, hand-written corner sequences,
// then random traffic against a queue-based program-order model.
module tb_rob_param;
  localparam int DEPTH = 16, TAG_W = 4, NUM_WB = 3, DATA_W = 32, ADDR_W = 32, REG_W = 5;
  localparam int AFULL = 2;

  logic clk = 1'b0;
  logic rst, rdy, alloc_valid, alloc_done;
  logic [REG_W-1:0] alloc_dest;
  logic [2:0] alloc_type;
  logic [TAG_W-1:0] alloc_tag;
  logic full_o;
  logic [TAG_W:0] count_o;
  logic q1_valid, q2_valid, q1_hit, q2_hit;
  logic [TAG_W-1:0] q1_tag, q2_tag;
  logic [DATA_W-1:0] q1_data, q2_data;
  logic [NUM_WB-1:0] wb_valid, wb_jump;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB*ADDR_W-1:0] wb_pc;
  logic commit_valid, lsb_commit, redirect_valid, flush;
  logic [REG_W-1:0] commit_dest;
  logic [TAG_W-1:0] commit_tag;
  logic [DATA_W-1:0] commit_data;
  logic [ADDR_W-1:0] redirect_pc;

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .DATA_W(DATA_W),
              .ADDR_W(ADDR_W), .REG_W(REG_W), .AFULL_MARGIN(AFULL)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .alloc_valid(alloc_valid), .alloc_done(alloc_done),
    .alloc_dest(alloc_dest), .alloc_type(alloc_type), .alloc_tag(alloc_tag),
    .full_o(full_o), .count_o(count_o),
    .q1_valid(q1_valid), .q1_tag(q1_tag), .q1_hit(q1_hit), .q1_data(q1_data),
    .q2_valid(q2_valid), .q2_tag(q2_tag), .q2_hit(q2_hit), .q2_data(q2_data),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_jump(wb_jump), .wb_pc(wb_pc),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_tag(commit_tag),
    .commit_data(commit_data), .lsb_commit(lsb_commit), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; alloc_valid = 1'b0; alloc_done = 1'b0; alloc_dest = '0; alloc_type = '0;
    q1_valid = 1'b0; q1_tag = '0; q2_valid = 1'b0; q2_tag = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_jump = '0; wb_pc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                        input logic [ADDR_W-1:0] pc, input logic j);
    wb_valid[p] = 1'b1;
    wb_tag[p*TAG_W +: TAG_W] = t;
    wb_data[p*DATA_W +: DATA_W] = d;
    wb_pc[p*ADDR_W +: ADDR_W] = pc;
    wb_jump[p] = j;
  endtask

  task automatic alloc(input logic [2:0] ty, input logic [REG_W-1:0] dst, input logic dn);
    alloc_valid = 1'b1; alloc_type = ty; alloc_dest = dst; alloc_done = dn;
  endtask

  // ---------------- behavioural model: program-order queue of live entries ----------------
  typedef struct {
    int tag; bit done; logic [DATA_W-1:0] data; logic [ADDR_W-1:0] pc;
    bit jump; logic [REG_W-1:0] dest; logic [2:0] typ;
  } ent_t;
  ent_t mq[$];
  int m_tail;
  logic e_cv, e_lsb, e_rv, e_fl;
  logic [REG_W-1:0] e_cdest;
  logic [TAG_W-1:0] e_ctag;
  logic [DATA_W-1:0] e_cdata;
  logic [ADDR_W-1:0] e_rpc;

  task automatic model_reset();
    mq.delete(); m_tail = 0;
    e_cv = 0; e_lsb = 0; e_rv = 0; e_fl = 0; e_cdest = '0; e_ctag = '0; e_cdata = '0; e_rpc = '0;
  endtask

  function automatic int find_ent(input int t);
    foreach (mq[k]) if (mq[k].tag == t) return k;
    return -1;
  endfunction

  task automatic exp_query(input logic v, input logic [TAG_W-1:0] t,
                           output logic h, output logic [DATA_W-1:0] d);
    int k;
    h = 1'b0; d = '0;
    if (!v) return;
    k = find_ent(int'(t));
    if (k < 0) return;
    if (mq[k].done) begin h = 1'b1; d = mq[k].data; return; end
    if (!rdy || e_fl) return;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == t) begin
        h = 1'b1; d = wb_data[p*DATA_W +: DATA_W]; return;
      end
    end
  endtask

  task automatic model_edge();
    ent_t f, n;
    bit do_c, got;
    if (!rdy || e_fl) begin
      e_cv = 0; e_lsb = 0; e_rv = 0; e_fl = 0;
      return;
    end
    do_c = (mq.size() > 0) && mq[0].done;
    if (do_c) f = mq[0];
    foreach (mq[k]) begin
      got = 0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (!got && wb_valid[p] && int'(wb_tag[p*TAG_W +: TAG_W]) == mq[k].tag) begin
          got = 1;
          mq[k].done = 1; mq[k].data = wb_data[p*DATA_W +: DATA_W];
          mq[k].pc = wb_pc[p*ADDR_W +: ADDR_W]; mq[k].jump = wb_jump[p];
        end
      end
    end
    if (alloc_valid && mq.size() < DEPTH) begin
      n.tag = m_tail; n.done = alloc_done; n.data = '0; n.pc = '0; n.jump = 0;
      n.dest = alloc_dest; n.typ = alloc_type;
      mq.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
    e_cv = 0; e_lsb = 0; e_rv = 0; e_fl = 0;
    if (do_c) begin
      mq.delete(0);
      e_cv = (f.typ == 3'd0 || f.typ == 3'd2 || f.typ == 3'd4);
      e_lsb = (f.typ == 3'd1 || f.typ == 3'd2);
      e_cdest = f.dest; e_ctag = TAG_W'(f.tag); e_cdata = f.data;
      if (f.jump && (f.typ == 3'd3 || f.typ == 3'd4)) begin
        e_rv = 1; e_fl = 1; e_rpc = f.pc;
        mq.delete(); m_tail = 0;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic av; logic ad; logic [REG_W-1:0] adest; logic [2:0] atype;
    logic wv; logic [TAG_W-1:0] wtag; logic [DATA_W-1:0] wdata;
    int e_count; int e_tag; logic e_cv; logic e_lsb; logic [REG_W-1:0] e_cdest; logic [DATA_W-1:0] e_cdata;
  } vec_t;
  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    logic [DATA_W-1:0] d;
    int wb_next, budget;

    vt[0] = '{1'b1, 1'b0, 5'd5, 3'd0, 1'b0, 4'd0, 32'h0,    1, 1, 1'b0, 1'b0, 5'd0, 32'h0};
    vt[1] = '{1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 4'd0, 32'h1234, 1, 1, 1'b0, 1'b0, 5'd0, 32'h0};
    vt[2] = '{1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 4'd0, 32'h0,    0, 1, 1'b1, 1'b0, 5'd5, 32'h1234};
    vt[3] = '{1'b1, 1'b1, 5'd0, 3'd1, 1'b0, 4'd0, 32'h0,    1, 2, 1'b0, 1'b0, 5'd0, 32'h0};
    vt[4] = '{1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 4'd0, 32'h0,    0, 2, 1'b0, 1'b1, 5'd0, 32'h0};
    vt[5] = '{1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 4'd0, 32'h0,    0, 2, 1'b0, 1'b0, 5'd0, 32'h0};
    vt[6] = '{1'b1, 1'b0, 5'd7, 3'd2, 1'b0, 4'd0, 32'h0,    1, 3, 1'b0, 1'b0, 5'd0, 32'h0};
    vt[7] = '{1'b1, 1'b1, 5'd9, 3'd1, 1'b1, 4'd2, 32'hBEEF, 2, 4, 1'b0, 1'b0, 5'd0, 32'h0};
    vt[8] = '{1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 4'd0, 32'h0,    1, 4, 1'b1, 1'b1, 5'd7, 32'hBEEF};
    vt[9] = '{1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 4'd0, 32'h0,    0, 4, 1'b0, 1'b1, 5'd0, 32'h0};

    rst = 1'b1;
    idle_inputs();
    #2;
    check("reset_count", count_o, 0);
    check("reset_full", full_o, 0);
    check("reset_alloc_tag", alloc_tag, 0);
    check("reset_pulses", {commit_valid, lsb_commit, redirect_valid, flush}, 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      alloc_valid = vt[i].av; alloc_done = vt[i].ad; alloc_dest = vt[i].adest; alloc_type = vt[i].atype;
      if (vt[i].wv) set_wb(0, vt[i].wtag, vt[i].wdata, '0, 1'b0);
      tick();
      check($sformatf("vec%0d_count", i), count_o, vt[i].e_count);
      check($sformatf("vec%0d_alloc_tag", i), alloc_tag, vt[i].e_tag);
      check($sformatf("vec%0d_commit_valid", i), commit_valid, vt[i].e_cv);
      check($sformatf("vec%0d_lsb_commit", i), lsb_commit, vt[i].e_lsb);
      if (vt[i].e_cv) begin
        check($sformatf("vec%0d_commit_dest", i), commit_dest, vt[i].e_cdest);
        check($sformatf("vec%0d_commit_data", i), commit_data, vt[i].e_cdata);
      end
    end

    // same-tag write-back priority and bypass
    do_reset();
    for (int i = 0; i < 4; i++) begin alloc(3'd0, 5'(i + 1), 1'b0); tick(); end
    idle_inputs();
    set_wb(0, 4'd3, 32'hAAAA, '0, 1'b0);
    set_wb(2, 4'd3, 32'h5555, '0, 1'b0);
    set_wb(1, 4'd9, 32'h9999, '0, 1'b0);
    q1_valid = 1'b1; q1_tag = 4'd3;
    q2_valid = 1'b1; q2_tag = 4'd9;
    @(negedge clk);
    check("prio_bypass_hit", q1_hit, 1);
    check("prio_bypass_data", q1_data, 32'hAAAA);
    check("invalid_entry_hit", q2_hit, 0);
    tick();
    idle_inputs();
    q2_valid = 1'b1; q2_tag = 4'd3;
    #1;
    check("prio_stored_hit", q2_hit, 1);
    check("prio_stored_data", q2_data, 32'hAAAA);

    // fill to DEPTH, almost-full threshold, overflow drop, wrap after drain
    do_reset();
    for (int k = 1; k <= DEPTH + 1; k++) begin
      alloc(3'd0, 5'd1, 1'b0);
      tick();
      check($sformatf("fill%0d_full", k), full_o, (k >= DEPTH - AFULL) ? 1 : 0);
      check($sformatf("fill%0d_count", k), count_o, (k > DEPTH) ? DEPTH : k);
    end
    check("fill_alloc_tag_wrapped", alloc_tag, 0);
    idle_inputs();
    wb_next = 0;
    budget = 0;
    while (count_o != 0 && budget < 100) begin
      idle_inputs();
      for (int p = 0; p < NUM_WB; p++)
        if (wb_next < DEPTH) begin set_wb(p, 4'(wb_next), 32'(wb_next), '0, 1'b0); wb_next++; end
      tick();
      budget++;
    end
    check("drain_count", count_o, 0);
    check("drain_alloc_tag", alloc_tag, 0);
    idle_inputs();
    alloc(3'd0, 5'd2, 1'b0);
    tick();
    check("post_drain_alloc_tag", alloc_tag, 1);
    check("post_drain_count", count_o, 1);

    // mispredict commit, one-cycle flush, allocation during flush cycle
    do_reset();
    alloc(3'd4, 5'd3, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin alloc(3'd0, 5'd4, 1'b0); tick(); end
    idle_inputs();
    set_wb(1, 4'd0, 32'h48, 32'h100, 1'b1);
    tick();
    idle_inputs();
    tick();
    check("mp_commit_valid", commit_valid, 1);
    check("mp_commit_dest", commit_dest, 3);
    check("mp_commit_data", commit_data, 32'h48);
    check("mp_redirect_valid", redirect_valid, 1);
    check("mp_redirect_pc", redirect_pc, 32'h100);
    check("mp_flush", flush, 1);
    check("mp_count", count_o, 0);
    alloc(3'd0, 5'd6, 1'b0);
    set_wb(0, 4'd1, 32'h77, '0, 1'b0);
    tick();
    check("mp_flush_cleared", flush, 0);
    check("mp_redirect_cleared", redirect_valid, 0);
    check("mp_alloc_dropped", count_o, 0);
    check("mp_alloc_tag_next", alloc_tag, 0);
    idle_inputs();
    alloc(3'd0, 5'd6, 1'b0);
    tick();
    check("mp_realloc_count", count_o, 1);
    check("mp_realloc_tag", alloc_tag, 1);

    // asynchronous reset mid-run with a pending write-back
    do_reset();
    for (int i = 0; i < 5; i++) begin alloc(3'd0, 5'd1, 1'b0); tick(); end
    idle_inputs();
    set_wb(0, 4'd1, 32'hDEAD, '0, 1'b0);
    check("pre_rst_count", count_o, 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", count_o, 0);
    check("async_rst_full", full_o, 0);
    check("async_rst_alloc_tag", alloc_tag, 0);
    check("async_rst_pulses", {commit_valid, lsb_commit, redirect_valid, flush}, 0);
    tick();
    rst = 1'b0;

    // random traffic against the model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      rdy = ($urandom_range(15) != 0);
      alloc_valid = ($urandom_range(9) < 6);
      alloc_type = 3'($urandom_range(4));
      alloc_done = (alloc_type == 3'd1) ? 1'b1 : ($urandom_range(7) == 0);
      alloc_dest = 5'($urandom);
      for (int p = 0; p < NUM_WB; p++) begin
        if ($urandom_range(2) == 0) begin
          logic [TAG_W-1:0] t;
          if (mq.size() > 0 && $urandom_range(4) != 0)
            t = 4'(mq[$urandom_range(mq.size() - 1)].tag);
          else
            t = 4'($urandom);
          set_wb(p, t, $urandom, $urandom, ($urandom_range(7) == 0));
        end
      end
      q1_valid = $urandom_range(1); q1_tag = 4'($urandom);
      q2_valid = $urandom_range(1);
      q2_tag = (wb_valid[0] && $urandom_range(1) == 1) ? wb_tag[TAG_W-1:0] : 4'($urandom);
      @(negedge clk);
      check("rnd_alloc_tag", alloc_tag, m_tail);
      exp_query(q1_valid, q1_tag, h, d);
      check("rnd_q1_hit", q1_hit, h);
      check("rnd_q1_data", q1_data, d);
      exp_query(q2_valid, q2_tag, h, d);
      check("rnd_q2_hit", q2_hit, h);
      check("rnd_q2_data", q2_data, d);
      model_edge();
      tick();
      check("rnd_count", count_o, mq.size());
      check("rnd_full", full_o, ((DEPTH - mq.size()) <= AFULL) ? 1 : 0);
      check("rnd_commit_valid", commit_valid, e_cv);
      check("rnd_lsb_commit", lsb_commit, e_lsb);
      check("rnd_redirect_valid", redirect_valid, e_rv);
      check("rnd_flush", flush, e_fl);
      check("rnd_commit_dest", commit_dest, e_cdest);
      check("rnd_commit_tag", commit_tag, e_ctag);
      check("rnd_commit_data", commit_data, e_cdata);
      check("rnd_redirect_pc", redirect_pc, e_rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
